// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, issues req/ack word fetches and holds one instruction slot for decode.
// Optional MIPS branch delay slot is enabled by defining IF_DELAY_SLOT_EN.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_ack,
  input  logic [31:0] ibus_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_code,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DROP = 2'd2} state_t;

  state_t      state, state_nx;
  logic [31:0] pc;
  logic        halt;
  logic        req_nx;
  logic        slot_free, kill, start, misfetch, ack_take;

`ifdef IF_DELAY_SLOT_EN
  logic        pend_valid;
  logic [31:0] pend_pc;
  assign kill = flush;
`else
  assign kill = flush | redirect;
`endif

  assign slot_free = !inst_valid || !stall;
  assign start     = (state == IDLE) && slot_free && !halt && !kill && (pc[1:0] == 2'b00);
  assign misfetch  = (state == IDLE) && slot_free && !halt && !kill && (pc[1:0] != 2'b00);
  assign ack_take  = (state == REQ) && ibus_ack && !kill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ibus_req <= 1'b0;
    end else begin
      state    <= state_nx;
      ibus_req <= req_nx;
    end
  end

  // A squashed request that has not been acked must still complete on the bus (DROP).
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = REQ;
      REQ:     if (ibus_ack) state_nx = IDLE;
               else if (kill) state_nx = DROP;
      DROP:    if (ibus_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ibus_addr  <= RESET_PC;
      pc         <= RESET_PC;
      halt       <= 1'b0;
      inst_valid <= 1'b0;
      inst_code  <= 32'd0;
      inst_pc    <= 32'd0;
      inst_fault <= 1'b0;
`ifdef IF_DELAY_SLOT_EN
      pend_valid <= 1'b0;
      pend_pc    <= 32'd0;
`endif
    end else begin
      if (start) ibus_addr <= pc;

      if (kill) begin
        inst_valid <= 1'b0;
        inst_fault <= 1'b0;
      end else if (ack_take) begin
        inst_valid <= 1'b1;
        inst_code  <= ibus_rdata;
        inst_pc    <= ibus_addr;
        inst_fault <= 1'b0;
      end else if (misfetch) begin
        inst_valid <= 1'b1;
        inst_code  <= 32'd0;
        inst_pc    <= pc;
        inst_fault <= 1'b1;
      end else if (inst_valid && !stall) begin
        inst_valid <= 1'b0;
        inst_fault <= 1'b0;
      end

      if (flush || redirect) halt <= 1'b0;
      else if (misfetch)     halt <= 1'b1;

`ifdef IF_DELAY_SLOT_EN
      // The word acked alongside (or after) a redirect is the delay slot; the target follows it.
      if (flush) begin
        pc         <= redirect_pc;
        pend_valid <= 1'b0;
      end else if (ack_take) begin
        if (redirect)        pc <= redirect_pc;
        else if (pend_valid) pc <= pend_pc;
        else                 pc <= ibus_addr + 32'd4;
        pend_valid <= 1'b0;
      end else if (redirect) begin
        if (halt) begin
          pc <= redirect_pc;
        end else begin
          pend_valid <= 1'b1;
          pend_pc    <= redirect_pc;
        end
      end
`else
      if (kill)          pc <= redirect_pc;
      else if (ack_take) pc <= ibus_addr + 32'd4;
`endif
    end
  end

endmodule
